adder_tree_feeder: RTL
======================

ADDER_TREE_FEEDER -- requirements
Module: adder_tree_feeder

Interface
REQ-001 SHALL have parameter WIDTH, default 6, giving the bit width of each operand word.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit, serial word offered.
REQ-005 SHALL have port in_ready, output, 1 bit, feeder can accept a word.
REQ-006 SHALL have port in_data, input, WIDTH bits, serial operand word.
REQ-007 SHALL have port in_last, input, 1 bit, the offered word closes the frame.
REQ-008 SHALL have ports osum0_0_0_0, osum0_0_0_1, osum0_0_1_0, osum0_0_1_1, osum0_1_0_0, osum0_1_0_1, osum0_1_1_0, osum0_1_1_1, each an output of WIDTH bits, holding the parallel operand slots 0..7 in that order.
REQ-009 SHALL have port out_valid, output, 1 bit, a complete frame is on the slots.
REQ-010 SHALL have port out_ready, input, 1 bit, downstream takes the frame.
REQ-011 SHALL have port out_count, output, 4 bits, the number of words in the presented frame (1..8).

Function
REQ-012 SHALL implement a two-state FSM: FILL (collecting words) and HOLD (presenting a frame).
REQ-013 SHALL drive in_ready = 1 in FILL and 0 in HOLD; in_ready is combinational from state only.
REQ-014 SHALL accept a word when in_valid && in_ready, writing in_data into slot idx, where idx is a 3-bit write index starting at 0.
REQ-015 SHALL increment idx on each accepted word that does not close the frame.
REQ-016 SHALL close the frame on an accepted word with idx==7 or in_last==1, whichever comes first; in_last on slot 7 is not an error.
REQ-017 SHALL enter HOLD on the clock edge that accepts the closing word, so out_valid rises exactly 1 cycle after the closing accept.
REQ-018 SHALL set out_count on frame close to idx+1 of the closing word.
REQ-019 SHALL present short frames zero-padded: slots beyond the last written index read 0 while in HOLD.
REQ-020 SHALL hold all slots, out_count and out_valid stable in HOLD until out_ready==1.
REQ-021 SHALL, on out_valid && out_ready, return to FILL on that edge, clear out_valid, reset idx to 0, and clear all eight slots and out_count to 0.
REQ-022 SHALL NOT accept a word in the cycle the frame is released (in_ready is 0 in HOLD); the first word of the next frame is accepted at the earliest 1 cycle after release.
REQ-023 SHALL tolerate out_ready asserted early or continuously; a frame is released only when out_valid is 1.
REQ-024 SHALL ignore in_data and in_last when in_valid is 0.
REQ-025 SHALL leave slot contents unspecified to downstream while in FILL; only HOLD values are contractual.

Reset
REQ-026 SHALL, while rst_n==0, force state FILL, idx 0, all slots 0, out_count 0, out_valid 0, in_ready 0, and exp_sum 0 when present.
REQ-027 SHALL, when reset asserts mid-frame or in HOLD, discard the partial or held frame with no output handshake.
REQ-028 SHALL have in_ready rise combinationally once rst_n deasserts.

Configuration
REQ-029 SHALL recognise the macro ADDER_TREE_FEEDER_SUM_CHECK_EN.
REQ-030 SHALL, with the macro defined, add output port exp_sum of WIDTH+3 bits that accumulates the zero-extended value of every accepted word, is valid and stable in HOLD, and clears to 0 on frame release.
REQ-031 SHALL, without the macro, omit exp_sum and all accumulator logic, with all other behaviour identical.

Verification
REQ-032 Full frame: WIDTH=6, words 1..8 back-to-back, in_last on word 8 -> out_valid 1 cycle later, slots=1..8, out_count=8, exp_sum=36.
REQ-033 Short frame: words 63,63,63 with in_last on the third -> slots 0..2=63, slots 3..7=0, out_count=3, exp_sum=189.
REQ-034 Backpressure: out_ready held 0 for 10 cycles in HOLD with in_valid=1 -> in_ready=0, slots stable, no word consumed; release on cycle 11 -> next word lands in slot 0.
REQ-035 Max sum: eight words of 63 -> exp_sum=504 with no truncation; out_count=8.
REQ-036 Reset mid-frame: assert rst_n=0 after 4 accepted words -> all outputs 0; after release, a 2-word frame of 5,7 gives slots 5,7,0..0 and out_count=2.
REQ-037 Gapped input: in_valid toggled every other cycle over 8 words -> same frame as back-to-back, out_valid 1 cycle after the 8th accept.

Source files
------------

// File: rtl/adder_tree_feeder.sv
// adder_tree_feeder: packs serial operand words into an 8-slot parallel frame for an adder tree.
// Define ADDER_TREE_FEEDER_SUM_CHECK_EN to add the exp_sum running-total output.
module adder_tree_feeder #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic [WIDTH-1:0] osum0_0_0_0,
  output logic [WIDTH-1:0] osum0_0_0_1,
  output logic [WIDTH-1:0] osum0_0_1_0,
  output logic [WIDTH-1:0] osum0_0_1_1,
  output logic [WIDTH-1:0] osum0_1_0_0,
  output logic [WIDTH-1:0] osum0_1_0_1,
  output logic [WIDTH-1:0] osum0_1_1_0,
  output logic [WIDTH-1:0] osum0_1_1_1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_count
`ifdef ADDER_TREE_FEEDER_SUM_CHECK_EN
  ,
  output logic [WIDTH+2:0] exp_sum
`endif
);
  typedef enum logic {FILL, HOLD} state_t;
  state_t           r_state;
  logic [2:0]       r_idx;
  logic [WIDTH-1:0] r_slot [8];
  logic [3:0]       r_count;
  logic             r_valid;
  logic             w_acc;
  logic             w_close;
  // in_ready is held low throughout reset and rises as soon as rst_n releases
  assign in_ready = rst_n && (r_state == FILL);
  assign w_acc    = in_valid && in_ready;
  assign w_close  = w_acc && (r_idx == 3'd7 || in_last);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FILL;
      r_idx   <= 3'd0;
      r_count <= 4'd0;
      r_valid <= 1'b0;
      for (int i = 0; i < 8; i++) r_slot[i] <= '0;
    end else if (r_state == FILL) begin
      if (w_acc) begin
        r_slot[r_idx] <= in_data;
        r_idx         <= w_close ? r_idx : r_idx + 3'd1;
      end
      if (w_close) begin
        r_state <= HOLD;
        r_valid <= 1'b1;
        r_count <= {1'b0, r_idx} + 4'd1;
      end
    end else if (out_ready) begin
      r_state <= FILL;
      r_valid <= 1'b0;
      r_idx   <= 3'd0;
      r_count <= 4'd0;
      for (int i = 0; i < 8; i++) r_slot[i] <= '0;
    end
  end
`ifdef ADDER_TREE_FEEDER_SUM_CHECK_EN
  logic [WIDTH+2:0] r_sum;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sum <= '0;
    else if (r_state == HOLD && out_ready) r_sum <= '0;
    else if (w_acc) r_sum <= r_sum + {3'b000, in_data};
  end
  assign exp_sum = r_sum;
`endif
  assign out_valid   = r_valid;
  assign out_count   = r_count;
  assign osum0_0_0_0 = r_slot[0];
  assign osum0_0_0_1 = r_slot[1];
  assign osum0_0_1_0 = r_slot[2];
  assign osum0_0_1_1 = r_slot[3];
  assign osum0_1_0_0 = r_slot[4];
  assign osum0_1_0_1 = r_slot[5];
  assign osum0_1_1_0 = r_slot[6];
  assign osum0_1_1_1 = r_slot[7];
endmodule
